// File: rtl/xadac_vload_mem.sv
// ----------------------------------------------------------------------------
// xadac_vload_mem : in-order AR/R read responder over a preloadable vector memory
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module xadac_vload_mem #(
  parameter int Depth        = 4,
  parameter int Latency      = 2,
  parameter int MemWords     = 256,
  parameter int IdWidth      = 4,
  parameter int AddrWidth    = 32,
  parameter int VecDataWidth = 128
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic [IdWidth-1:0]      axi_ar_id,
  input  logic [AddrWidth-1:0]    axi_ar_addr,
  input  logic                    axi_ar_valid,
  output logic                    axi_ar_ready,
  output logic [IdWidth-1:0]      axi_r_id,
  output logic [VecDataWidth-1:0] axi_r_data,
  output logic                    axi_r_valid,
  input  logic                    axi_r_ready,
  input  logic                    mem_we,
  input  logic [AddrWidth-1:0]    mem_waddr,
  input  logic [VecDataWidth-1:0] mem_wdata
);

  localparam int VecBytes = VecDataWidth / 8;
  localparam int OffW     = $clog2(VecBytes);
  localparam int IdxW     = (MemWords > 1) ? $clog2(MemWords) : 1;
  localparam int CntW     = $clog2(Depth + 1);
  localparam int PtrW     = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int LatW     = (Latency > 0) ? $clog2(Latency + 1) : 1;

  logic [VecDataWidth-1:0] mem_q [MemWords];

  logic [IdWidth-1:0] id_q  [Depth];
  logic [IdxW-1:0]    idx_q [Depth];
  logic [LatW-1:0]    cd_q  [Depth];
  logic [PtrW-1:0]    head_q, tail_q;
  logic [CntW-1:0]    count_q;

  logic                    rvalid_q;
  logic [IdWidth-1:0]      rid_q;
  logic [VecDataWidth-1:0] rdata_q;

  logic                    w_push, w_pop;
  logic [IdxW-1:0]         w_ar_idx, w_wr_idx, w_head_idx;
  logic [VecDataWidth-1:0] w_rdata;
  logic [PtrW-1:0]         w_head_nxt, w_tail_nxt;
  logic                    w_unused;

  // Sub-word bits and bits above the array size are dropped, so addresses wrap.
  assign w_ar_idx = IdxW'(axi_ar_addr >> OffW);
  assign w_wr_idx = IdxW'(mem_waddr >> OffW);
  assign w_unused = ^{axi_ar_addr, mem_waddr};

  // Ready depends only on the registered occupancy; a same-cycle pop does not help.
  assign axi_ar_ready = rstn && (count_q < CntW'(Depth));

  assign w_push     = axi_ar_valid && axi_ar_ready;
  assign w_pop      = (count_q != '0) && (cd_q[head_q] == '0) && (!rvalid_q || axi_r_ready);
  assign w_head_idx = idx_q[head_q];
  assign w_head_nxt = (head_q == PtrW'(Depth - 1)) ? '0 : head_q + PtrW'(1);
  assign w_tail_nxt = (tail_q == PtrW'(Depth - 1)) ? '0 : tail_q + PtrW'(1);

  // A preload landing on the same edge as the read wins.
  assign w_rdata = (mem_we && (w_wr_idx == w_head_idx)) ? mem_wdata : mem_q[w_head_idx];

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[w_wr_idx] <= mem_wdata;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      head_q   <= '0;
      tail_q   <= '0;
      count_q  <= '0;
      rvalid_q <= 1'b0;
      rid_q    <= '0;
      rdata_q  <= '0;
      for (int i = 0; i < Depth; i++) begin
        id_q[i]  <= '0;
        idx_q[i] <= '0;
        cd_q[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < Depth; i++) begin
        if (cd_q[i] != '0) begin
          cd_q[i] <= cd_q[i] - LatW'(1);
        end
      end

      if (w_push) begin
        id_q[tail_q]  <= axi_ar_id;
        idx_q[tail_q] <= w_ar_idx;
        cd_q[tail_q]  <= LatW'(Latency);
        tail_q        <= w_tail_nxt;
      end

      if (w_pop) begin
        head_q   <= w_head_nxt;
        rvalid_q <= 1'b1;
        rid_q    <= id_q[head_q];
        rdata_q  <= w_rdata;
      end else if (rvalid_q && axi_r_ready) begin
        rvalid_q <= 1'b0;
        rid_q    <= '0;
        rdata_q  <= '0;
      end

      case ({w_push, w_pop})
        2'b10:   count_q <= count_q + CntW'(1);
        2'b01:   count_q <= count_q - CntW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign axi_r_valid = rvalid_q;
  assign axi_r_id    = rid_q;
  assign axi_r_data  = rdata_q;

endmodule

`default_nettype wire

// File: tb/tb_xadac_vload_mem.sv
// ----------------------------------------------------------------------------
// tb_xadac_vload_mem : directed + randomized bench against a queue-based model
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_xadac_vload_mem;

  localparam int DEPTH = 4;
  localparam int LAT   = 2;
  localparam int MEMW  = 256;
  localparam int IDW   = 4;
  localparam int AW    = 32;
  localparam int DW    = 128;
  localparam int VB    = DW / 8;

  logic           clk = 1'b0;
  logic           rstn = 1'b1;
  logic [IDW-1:0] axi_ar_id = '0;
  logic [AW-1:0]  axi_ar_addr = '0;
  logic           axi_ar_valid = 1'b0;
  logic           axi_ar_ready;
  logic [IDW-1:0] axi_r_id;
  logic [DW-1:0]  axi_r_data;
  logic           axi_r_valid;
  logic           axi_r_ready = 1'b1;
  logic           mem_we = 1'b0;
  logic [AW-1:0]  mem_waddr = '0;
  logic [DW-1:0]  mem_wdata = '0;

  xadac_vload_mem #(
    .Depth(DEPTH), .Latency(LAT), .MemWords(MEMW),
    .IdWidth(IDW), .AddrWidth(AW), .VecDataWidth(DW)
  ) dut (
    .clk(clk), .rstn(rstn),
    .axi_ar_id(axi_ar_id), .axi_ar_addr(axi_ar_addr),
    .axi_ar_valid(axi_ar_valid), .axi_ar_ready(axi_ar_ready),
    .axi_r_id(axi_r_id), .axi_r_data(axi_r_data),
    .axi_r_valid(axi_r_valid), .axi_r_ready(axi_r_ready),
    .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: shadow memory, FIFO of pending requests with the edge at
  // which each may first leave, and the expected output register.
  typedef struct {
    logic [IDW-1:0] id;
    int             idx;
    longint         elig;
  } ent_t;

  logic [DW-1:0]  shadow [MEMW];
  ent_t           q [$];
  longint         edge_n = 0;
  logic           m_rvalid = 1'b0;
  logic [IDW-1:0] m_rid = '0;
  logic [DW-1:0]  m_rdata = '0;
  logic           last_ar_hs = 1'b0;

  function automatic int word_of(logic [AW-1:0] a);
    return int'((longint'(a) / VB) % MEMW);
  endfunction

  function automatic logic [DW-1:0] rnd_vec();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic check(string tag, logic [DW-1:0] got, logic [DW-1:0] exp);
    vectors++;
    assert (got === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_rvalid = 1'b0;
    m_rid    = '0;
    m_rdata  = '0;
  endtask

  task automatic tick();
    logic           ready_m, ar_hs, r_hs, rv_pre, we_s;
    logic [IDW-1:0] id_s;
    logic [AW-1:0]  addr_s, waddr_s;
    logic [DW-1:0]  wdata_s;
    #1;
    ready_m = rstn && (q.size() < DEPTH);
    check("ar_ready", DW'(axi_ar_ready), DW'(ready_m));
    ar_hs   = axi_ar_valid && ready_m;
    r_hs    = m_rvalid && axi_r_ready;
    rv_pre  = m_rvalid;
    id_s    = axi_ar_id;
    addr_s  = axi_ar_addr;
    we_s    = mem_we;
    waddr_s = mem_waddr;
    wdata_s = mem_wdata;
    @(posedge clk);
    edge_n++;
    last_ar_hs = ar_hs;
    if (we_s) shadow[word_of(waddr_s)] = wdata_s;
    if (!rstn) begin
      model_reset();
    end else begin
      if (r_hs) begin
        m_rvalid = 1'b0;
        m_rid    = '0;
        m_rdata  = '0;
      end
      if (q.size() > 0 && q[0].elig <= edge_n && (!rv_pre || r_hs)) begin
        m_rvalid = 1'b1;
        m_rid    = q[0].id;
        m_rdata  = shadow[q[0].idx];
        void'(q.pop_front());
      end
      if (ar_hs) q.push_back('{id: id_s, idx: word_of(addr_s), elig: edge_n + 1 + LAT});
    end
    #1;
    check("r_valid", DW'(axi_r_valid), DW'(m_rvalid));
    check("r_id", DW'(axi_r_id), DW'(m_rid));
    check("r_data", axi_r_data, m_rdata);
  endtask

  initial begin
    logic [DW-1:0] a5, newv;
    a5 = {16{8'hA5}};

    // Asynchronous reset assertion
    #2 rstn = 1'b0;
    #1;
    check("rst_r_valid", DW'(axi_r_valid), '0);
    check("rst_r_id", DW'(axi_r_id), '0);
    check("rst_r_data", axi_r_data, '0);
    check("rst_ar_ready", DW'(axi_ar_ready), '0);
    tick();
    tick();
    rstn = 1'b1;

    // Preload every word, then word 3 with a recognisable pattern
    for (int w = 0; w < MEMW; w++) begin
      mem_we    = 1'b1;
      mem_waddr = AW'(w * VB);
      mem_wdata = rnd_vec();
      tick();
    end
    mem_waddr = AW'(3 * VB);
    mem_wdata = a5;
    tick();
    mem_we = 1'b0;
    repeat (2) tick();

    // Single request: latency and data
    axi_r_ready  = 1'b1;
    axi_ar_valid = 1'b1;
    axi_ar_id    = 4'd1;
    axi_ar_addr  = AW'(3 * VB);
    tick();
    axi_ar_valid = 1'b0;
    repeat (2) tick();
    check("lat_early", DW'(axi_r_valid), '0);
    tick();
    check("lat_valid", DW'(axi_r_valid), DW'(1'b1));
    check("lat_id", DW'(axi_r_id), DW'(4'd1));
    check("lat_data", axi_r_data, a5);
    tick();
    check("lat_single", DW'(axi_r_valid), '0);

    // Back-to-back requests
    for (int i = 0; i < 4; i++) begin
      axi_ar_valid = 1'b1;
      axi_ar_id    = IDW'(i);
      axi_ar_addr  = AW'(i * VB);
      tick();
    end
    axi_ar_valid = 1'b0;
    repeat (6) tick();

    // Backpressure: fill buffer and output register
    axi_r_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      axi_ar_valid = 1'b1;
      axi_ar_id    = IDW'(i + 4);
      axi_ar_addr  = $urandom;
      if (i < 5 || !last_ar_hs) tick();
    end
    check("full_ar_ready", DW'(axi_ar_ready), '0);
    axi_r_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (last_ar_hs) axi_ar_valid = 1'b0;
    end
    axi_ar_valid = 1'b0;

    // Address wrap and sub-word bits ignored
    axi_ar_valid = 1'b1;
    axi_ar_id    = 4'd9;
    axi_ar_addr  = AW'(MEMW * VB + VB + 5);
    tick();
    axi_ar_valid = 1'b0;
    repeat (3) tick();
    check("wrap_data", axi_r_data, shadow[1]);
    tick();

    // Preload write bypass on the same edge as the read
    newv = rnd_vec();
    axi_ar_valid = 1'b1;
    axi_ar_id    = 4'd7;
    axi_ar_addr  = AW'(7 * VB);
    tick();
    axi_ar_valid = 1'b0;
    repeat (2) tick();
    mem_we    = 1'b1;
    mem_waddr = AW'(7 * VB);
    mem_wdata = newv;
    tick();
    mem_we = 1'b0;
    check("bypass_data", axi_r_data, newv);
    tick();

    // Reset with requests outstanding
    axi_r_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      axi_ar_valid = 1'b1;
      axi_ar_id    = IDW'(10 + i);
      axi_ar_addr  = AW'((20 + i) * VB);
      tick();
    end
    axi_ar_valid = 1'b0;
    check("pre_rst_valid", DW'(axi_r_valid), DW'(1'b1));
    #2 rstn = 1'b0;
    #1;
    model_reset();
    check("arst_r_valid", DW'(axi_r_valid), '0);
    check("arst_r_id", DW'(axi_r_id), '0);
    check("arst_r_data", axi_r_data, '0);
    check("arst_ar_ready", DW'(axi_ar_ready), '0);
    tick();
    tick();
    rstn = 1'b1;
    axi_r_ready = 1'b1;
    repeat (8) tick();
    axi_ar_valid = 1'b1;
    axi_ar_id    = 4'd2;
    axi_ar_addr  = AW'(3 * VB);
    tick();
    axi_ar_valid = 1'b0;
    repeat (3) tick();
    check("persist_data", axi_r_data, a5);
    tick();

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      axi_ar_valid = ($urandom_range(0, 9) < 6);
      axi_ar_id    = IDW'($urandom);
      axi_ar_addr  = $urandom;
      axi_r_ready  = ($urandom_range(0, 9) < 7);
      mem_we       = ($urandom_range(0, 9) < 2);
      mem_waddr    = ($urandom_range(0, 1) == 0) ? AW'($urandom_range(0, 7) * VB) : $urandom;
      mem_wdata    = rnd_vec();
      tick();
    end
    axi_ar_valid = 1'b0;
    mem_we       = 1'b0;
    axi_r_ready  = 1'b1;
    repeat (10) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
